// File: rtl/decode_pkg.sv
// Shared opcode encoding, instruction field positions and NOP constant for the decode slice.
package decode_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_ADDI  = 4'hA,
        OP_BEQ   = 4'hB,
        OP_BNE   = 4'hC,
        OP_JMP   = 4'hD,
        OP_LUI   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    localparam int FIELD_W = 4;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef logic [FIELD_W-1:0] regaddr_t;

    function automatic regaddr_t field(input logic [15:0] instr, input int lsb);
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 16-entry register file: two combinational reads, one synchronous write, r0 hardwired to zero.
// Same-cycle writeback forwarding is enabled by defining DECODE_WB_BYPASS_EN.
module register_file
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  regaddr_t          raddr1,
    input  regaddr_t          raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  regaddr_t          waddr,
    input  logic [DATA_W-1:0] wdata
);

    // No reset on the array: contents are undefined until software writes them.
    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
`ifdef DECODE_WB_BYPASS_EN
        if (we && waddr != '0 && waddr == raddr1) begin
            rdata1 = wdata;
        end
`endif
    end

    always_comb begin
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
`ifdef DECODE_WB_BYPASS_EN
        if (we && waddr != '0 && waddr == raddr2) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, load-use hazard stall, register-file read, ID/EX register.
// Register-file writeback bypass is selected with DECODE_WB_BYPASS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction,
    input  logic              flush,
    input  logic              wbEn,
    input  logic [3:0]        wbAddr,
    input  logic [DATA_W-1:0] wbData,
    output logic              pcHold,
    output logic              exValid,
    output logic [3:0]        exOpcode,
    output logic [3:0]        exRd,
    output logic [DATA_W-1:0] exRs1Data,
    output logic [DATA_W-1:0] exRs2Data,
    output logic [DATA_W-1:0] exImm,
    output logic              exMemRead
);

    logic [15:0]       id_instr;
    logic              id_valid;
    regaddr_t          id_opc;
    regaddr_t          id_rd;
    regaddr_t          id_rs1;
    regaddr_t          id_rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              hazard;
    logic              bubble;

    assign id_opc = field(id_instr, OPC_LSB);
    assign id_rd  = field(id_instr, RD_LSB);
    assign id_rs1 = field(id_instr, RS1_LSB);
    assign id_rs2 = field(id_instr, RS2_LSB);

    register_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_register_file (
        .clk    (clk),
        .raddr1 (id_rs1),
        .raddr2 (id_rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (wbEn),
        .waddr  (wbAddr),
        .wdata  (wbData)
    );

    // The bubble inserted on a stall clears exValid, so the match cannot persist past one cycle.
    always_comb begin
        hazard = 1'b0;
        if (exValid && exMemRead && exRd != '0 && id_valid) begin
            hazard = (exRd == id_rs1) || (exRd == id_rs2);
        end
    end

    assign pcHold = hazard && !flush;
    assign bubble = flush || hazard || !id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (!hazard) begin
            id_instr <= instruction;
            id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exValid   <= 1'b0;
            exOpcode  <= '0;
            exRd      <= '0;
            exRs1Data <= '0;
            exRs2Data <= '0;
            exImm     <= '0;
            exMemRead <= 1'b0;
        end else if (bubble) begin
            exValid   <= 1'b0;
            exOpcode  <= '0;
            exRd      <= '0;
            exRs1Data <= '0;
            exRs2Data <= '0;
            exImm     <= '0;
            exMemRead <= 1'b0;
        end else begin
            exValid   <= 1'b1;
            exOpcode  <= id_opc;
            exRd      <= id_rd;
            exRs1Data <= rs1_data;
            exRs2Data <= rs2_data;
            exImm     <= DATA_W'(id_rs2);
            exMemRead <= (id_opc == OP_LOAD);
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, 32, width of register-file data and ID/EX operand outputs.
REQ-002 Parameter NREGS, 16, number of architectural registers; fixed at 16 by the 4-bit register fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 instruction  input  16  fetched instruction from the fetch stage, valid every cycle.
REQ-006 flush  input  1  discard the IF/ID contents (taken branch resolved downstream).
REQ-007 wbEn  input  1  register-file write enable from writeback.
REQ-008 wbAddr  input  4  writeback destination register.
REQ-009 wbData  input  DATA_W  writeback data.
REQ-010 pcHold  output  1  combinational; high means fetch shall hold its PC and instruction this cycle.
REQ-011 exValid  output  1  registered; ID/EX slot holds a real instruction.
REQ-012 exOpcode  output  4  registered; instruction[15:12].
REQ-013 exRd  output  4  registered; instruction[11:8].
REQ-014 exRs1Data, exRs2Data  output  DATA_W each  registered operand values.
REQ-015 exImm  output  DATA_W  registered; instruction[3:0] zero-extended.
REQ-016 exMemRead  output  1  registered; exOpcode equals LOAD.

Function
REQ-017 IF/ID register SHALL capture instruction each cycle and set idValid=1, unless held or flushed.
REQ-018 Field split SHALL be: opcode [15:12], rd [11:8], rs1 [7:4], rs2/imm [3:0].
REQ-019 Load-use hazard SHALL be detected when exValid=1, exMemRead=1, exRd!=0, and exRd equals rs1 or rs2 of a valid IF/ID instruction.
REQ-020 On hazard: pcHold=1, IF/ID SHALL hold its contents, and the ID/EX slot SHALL load a bubble (exValid=0, all other ex outputs 0).
REQ-021 A hazard SHALL stall for exactly one cycle; the bubble removes the match on the next cycle.
REQ-022 flush SHALL load IF/ID with NOP 16'h0000 and idValid=0 on the next edge.
REQ-023 flush and a same-cycle hazard: flush wins; IF/ID loads NOP, ID/EX loads a bubble, and pcHold is 0.
REQ-024 Latency: an instruction present at edge N SHALL appear on the ex outputs after edge N+1 (2 cycles), absent stalls.
REQ-025 Register file: 16 x DATA_W entries, 2 combinational read ports, 1 synchronous write port.
REQ-026 Register 0 SHALL read as 0; writes to it are ignored.
REQ-027 The register file SHALL NOT be cleared by reset; its contents are undefined until written.
REQ-028 A write with wbAddr equal to the value held in ID/EX SHALL NOT modify that registered operand.
REQ-029 An invalid IF/ID instruction SHALL propagate as exValid=0 and SHALL NOT trigger a hazard.

Reset
REQ-030 While reset=1: IF/ID holds NOP with idValid=0, all ex outputs are 0, and pcHold is 0.
REQ-031 Reset asserted mid-stall SHALL abandon the stall; the first post-reset instruction decodes normally.

Configuration
REQ-032 Macro DECODE_WB_BYPASS_EN defined: a read whose address matches wbAddr with wbEn=1 (and address nonzero) SHALL return wbData in the same cycle.
REQ-033 DECODE_WB_BYPASS_EN undefined: such a read SHALL return the old register value, and software must insert a gap.

Structure
REQ-034 Package decode_pkg SHALL hold the opcode enum (including LOAD=4'h8), the field-position constants, and NOP_INSTR=16'h0000.
REQ-035 Sub-module register_file SHALL implement REQ-025/026/032/033; the hazard logic and pipeline registers stay in decode_stage.

Verification
REQ-036 Reset, then instruction 16'h1123 (rd=1, rs1=2, rs2=3) -> after 2 edges: exValid=1, exOpcode=1, exRd=1, exImm=3.
REQ-037 LOAD r5 followed by an ADD using rs1=r5 -> pcHold=1 for exactly one cycle, one bubble (exValid=0), then the ADD issues with exValid=1.
REQ-038 LOAD r0 followed by a consumer of r0 -> no stall, pcHold stays 0.
REQ-039 flush asserted during a load-use hazard -> pcHold=0, two consecutive exValid=0 cycles.
REQ-040 Write r7=0xDEADBEEF while r7 is being read -> exRs1Data=0xDEADBEEF with DECODE_WB_BYPASS_EN, old value without it.
REQ-041 Reset pulse mid-stall -> all ex outputs 0 and pcHold=0 immediately; next instruction completes in 2 cycles.
